cpu_decode: RTL

- Instruction decode stage, directly downstream of the instruction fetch unit.
- Consumes the 16-bit instruction window plus the following 32-bit data window from the fetch buffer.
- Classifies the moxie instruction form, extracts register fields and immediate, and tracks the instruction PC.
- Returns halfword-consumption strobes to fetch and presents one registered decoded instruction per cycle to execute.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/cpu_decode_if.sv | 41 ++++
 rtl/cpu_decode_classify.sv | 39 +++
 rtl/cpu_decode.sv | 79 +++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the moxie decode stage.
package cpu_pkg;

    typedef enum logic [1:0] {
        FORM1     = 2'd0,
        FORM1_IMM = 2'd1,
        FORM2     = 2'd2,
        FORM3     = 2'd3
    } form_e;

    typedef enum logic {
        S_RUN      = 1'b0,
        S_WAITDATA = 1'b1
    } state_e;

    localparam logic [7:0]  MAX_FORM1_OP     = 8'h39;
    localparam logic [31:0] DEF_BOOT_ADDRESS = 32'h0000_1000;

    // Bit n set => form1 opcode n carries a trailing 32-bit immediate.
    localparam logic [63:0] LONG_IMM_OPS =
        (64'd1 << 8'h01) | (64'd1 << 8'h03) | (64'd1 << 8'h08) |
        (64'd1 << 8'h09) | (64'd1 << 8'h0c) | (64'd1 << 8'h0d) |
        (64'd1 << 8'h1a) | (64'd1 << 8'h1b) | (64'd1 << 8'h1d) |
        (64'd1 << 8'h1f) | (64'd1 << 8'h20) | (64'd1 << 8'h22) |
        (64'd1 << 8'h24) | (64'd1 << 8'h30) | (64'd1 << 8'h36) |
        (64'd1 << 8'h37) | (64'd1 << 8'h38) | (64'd1 << 8'h39);

    typedef struct packed {
        form_e       form;
        logic        need_data;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    function automatic logic is_long_imm(input logic [7:0] op);
        return (op[7:6] == 2'b00) && LONG_IMM_OPS[op[5:0]];
    endfunction

endpackage

// File: rtl/cpu_decode_if.sv
// Fetch/decode/execute signal bundle around the decode stage.
interface cpu_decode_if;
    import cpu_pkg::*;

    logic [15:0] ifid_insn;
    logic [31:0] ifid_insn_data;
    logic        ifid_insn_valid;
    logic        ifid_insn_data_valid;
    logic        idif_used_insn;
    logic        idif_used_data;
    logic        ex_stall;
    logic        ex_flush;
    logic [31:0] ex_redirect_pc;
    logic        idex_valid;
    logic [15:0] idex_insn;
    form_e       idex_form;
    logic [3:0]  idex_ra;
    logic [3:0]  idex_rb;
    logic [31:0] idex_imm;
    logic [31:0] idex_pc;
    logic        idex_illegal;

    modport master (
        output ifid_insn, ifid_insn_data, ifid_insn_valid,
        output ifid_insn_data_valid,
        output ex_stall, ex_flush, ex_redirect_pc,
        input  idif_used_insn, idif_used_data,
        input  idex_valid, idex_insn, idex_form, idex_ra, idex_rb,
        input  idex_imm, idex_pc, idex_illegal
    );

    modport slave (
        input  ifid_insn, ifid_insn_data, ifid_insn_valid,
        input  ifid_insn_data_valid,
        input  ex_stall, ex_flush, ex_redirect_pc,
        output idif_used_insn, idif_used_data,
        output idex_valid, idex_insn, idex_form, idex_ra, idex_rb,
        output idex_imm, idex_pc, idex_illegal
    );

endinterface

// File: rtl/cpu_decode_classify.sv
// Combinational moxie instruction classifier: form, fields, immediate.
module cpu_decode_classify
    import cpu_pkg::*;
(
    input  logic [15:0] insn,
    input  logic [31:0] data,
    output dec_t        dec
);

    logic [7:0] op;
    assign op = insn[15:8];

    always_comb begin
        dec = '0;
        dec.form = FORM1;
        unique case (1'b1)
            !insn[15]: begin
                dec.ra        = insn[7:4];
                dec.rb        = insn[3:0];
                dec.illegal   = op > MAX_FORM1_OP;
                dec.need_data = is_long_imm(op);
                if (dec.need_data) begin
                    dec.form = FORM1_IMM;
                    dec.imm  = data;
                end
            end
            insn[15:14] == 2'b10: begin
                dec.form = FORM2;
                dec.ra   = insn[11:8];
                dec.imm  = {24'd0, insn[7:0]};
            end
            default: begin
                dec.form = FORM3;
                dec.imm  = {{21{insn[9]}}, insn[9:0], 1'b0};
            end
        endcase
    end

endmodule

// File: rtl/cpu_decode.sv
// Decode stage: consumes fetch window, registers one decoded insn for execute.
module cpu_decode
    import cpu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = DEF_BOOT_ADDRESS,
    parameter int          STALL_CNT_W  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cpu_decode_if.slave            dif,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    dec_t        dec;
    state_e      state;
    logic [31:0] pc;
    logic        accept;
    logic        go;
    logic        starve;

    cpu_decode_classify u_classify (
        .insn (dif.ifid_insn),
        .data (dif.ifid_insn_data),
        .dec  (dec)
    );

    assign accept = !dif.idex_valid || !dif.ex_stall;
    assign go     = dif.ifid_insn_valid && accept && !dif.ex_flush &&
                    (!dec.need_data || dif.ifid_insn_data_valid);
    assign starve = dif.ifid_insn_valid && dec.need_data &&
                    !dif.ifid_insn_data_valid && accept && !dif.ex_flush;

    assign dif.idif_used_insn = go;
    assign dif.idif_used_data = go && dec.need_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= S_RUN;
            pc               <= BOOT_ADDRESS;
            stall_cnt_o      <= '0;
            dif.idex_valid   <= 1'b0;
            dif.idex_insn    <= '0;
            dif.idex_form    <= FORM1;
            dif.idex_ra      <= '0;
            dif.idex_rb      <= '0;
            dif.idex_imm     <= '0;
            dif.idex_pc      <= '0;
            dif.idex_illegal <= 1'b0;
        end else begin
            if (state == S_WAITDATA && stall_cnt_o != '1)
                stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);

            unique case (state)
                S_RUN:      if (starve) state <= S_WAITDATA;
                S_WAITDATA: if (go || dif.ex_flush) state <= S_RUN;
                default:    state <= S_RUN;
            endcase

            // Flush outranks a same-cycle consumption.
            if (dif.ex_flush) begin
                dif.idex_valid <= 1'b0;
                pc             <= dif.ex_redirect_pc;
            end else if (go) begin
                dif.idex_valid   <= 1'b1;
                dif.idex_insn    <= dif.ifid_insn;
                dif.idex_form    <= dec.form;
                dif.idex_ra      <= dec.ra;
                dif.idex_rb      <= dec.rb;
                dif.idex_imm     <= dec.imm;
                dif.idex_pc      <= pc;
                dif.idex_illegal <= dec.illegal;
                pc <= pc + (dec.need_data ? 32'd6 : 32'd2);
            end else if (accept) begin
                dif.idex_valid <= 1'b0;
            end
        end
    end

endmodule
